// File: rtl/mem_responder_if.sv
// Request/response bus between the multi-cycle controller and the unified memory responder.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, a, wd,
    input  rd, ready, busy, err
  );

  modport slave (
    input  req, we, a, wd,
    output rd, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data word store with a fixed-latency IDLE/WAIT/RESP handshake
// and fault reporting for misaligned or out-of-range byte addresses.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WORD_W   = 32;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
  localparam bit          ZERO_LAT = (LATENCY == 0);

  if (DEPTH_WORDS < 4 || DEPTH_WORDS > 1024 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("mem_responder: DEPTH_WORDS must be a power of two in 4..1024");
  end
  if (LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [WORD_W-1:0]   a_q;
  logic [WORD_W-1:0]   wd_q;
  logic [WORD_W-1:0]   rd_q;
  logic                ready_q;
  logic                busy_q;
  logic                err_q;
  logic [WORD_W-1:0]   mem_q [DEPTH_WORDS];

  logic                accept_c;
  logic                wait_done_c;
  logic                enter_resp_c;
  logic                acc_we_c;
  logic [WORD_W-1:0]   acc_a_c;
  logic [WORD_W-1:0]   acc_wd_c;
  logic [IDX_W-1:0]    acc_idx_c;
  logic                acc_fault_c;

  // Access resolved on the RESP-entry edge: live inputs for zero latency, latched otherwise
  always_comb begin
    accept_c    = (state_q == IDLE) && bus.req;
    wait_done_c = (state_q == WAIT) && (cnt_q == CNT_W'(1));
    acc_we_c    = we_q;
    acc_a_c     = a_q;
    acc_wd_c    = wd_q;
    if (state_q == IDLE) begin
      acc_we_c = bus.we;
      acc_a_c  = bus.a;
      acc_wd_c = bus.wd;
    end
    acc_idx_c    = acc_a_c[IDX_W+1:2];
    acc_fault_c  = (acc_a_c[1:0] != 2'b00) ||
                   (acc_a_c[31:2] >= 30'(DEPTH_WORDS));
    enter_resp_c = reset && ((accept_c && ZERO_LAT) || wait_done_c);
  end

  // Handshake FSM with registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            a_q     <= bus.a;
            wd_q    <= bus.wd;
            cnt_q   <= LAT_C;
            busy_q  <= 1'b1;
            state_q <= ZERO_LAT ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (wait_done_c) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase

      // rd/err change only here, so they hold until the next response
      if (enter_resp_c) begin
        ready_q <= 1'b1;
        err_q   <= acc_fault_c;
        rd_q    <= (!acc_we_c && !acc_fault_c) ? mem_q[acc_idx_c] : '0;
      end
    end
  end

  // Store is never reset; faulting writes are dropped
  always_ff @(posedge clk) begin
    if (enter_resp_c && acc_we_c && !acc_fault_c) begin
      mem_q[acc_idx_c] <= acc_wd_c;
    end
  end

  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one DUT at LATENCY=2 and one at LATENCY=0, both 64 words.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   nvec;
  int   nfail;

  mem_responder_if m2_if ();
  mem_responder_if m0_if ();

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (m2_if)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (m0_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      m0_if.req = r; m0_if.we = w; m0_if.a = addr; m0_if.wd = data;
    end else begin
      m2_if.req = r; m2_if.we = w; m2_if.a = addr; m2_if.wd = data;
    end
  endtask

  // Issue one request, then observe 8 cycles; report first-ready cycle and ready count
  task automatic xact(input int sel, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input bit scramble,
                      output int lat, output int nrdy,
                      output logic [31:0] rdv, output logic errv);
    logic r;
    lat  = -1;
    nrdy = 0;
    rdv  = '0;
    errv = 1'b0;
    drive(sel, 1'b1, w, addr, data);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        if (scramble) drive(sel, 1'b0, ~w, addr ^ 32'h4, ~data);
        else          drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      r = (sel == 0) ? m0_if.ready : m2_if.ready;
      if (r) begin
        nrdy++;
        if (lat < 0) begin
          lat  = k;
          rdv  = (sel == 0) ? m0_if.rd  : m2_if.rd;
          errv = (sel == 0) ? m0_if.err : m2_if.err;
        end
      end
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    nvec++; if (m2_if.ready !== 1'b0) begin nfail++; $display("FAIL reset_ready2 got %b want 0", m2_if.ready); end
    nvec++; if (m2_if.busy  !== 1'b0) begin nfail++; $display("FAIL reset_busy2 got %b want 0", m2_if.busy); end
    nvec++; if (m2_if.err   !== 1'b0) begin nfail++; $display("FAIL reset_err2 got %b want 0", m2_if.err); end
    nvec++; if (m2_if.rd !== 32'h0) begin nfail++; $display("FAIL reset_rd2 got %h want 00000000", m2_if.rd); end
    nvec++; if (m0_if.ready !== 1'b0) begin nfail++; $display("FAIL reset_ready0 got %b want 0", m0_if.ready); end
    nvec++; if (m0_if.busy  !== 1'b0) begin nfail++; $display("FAIL reset_busy0 got %b want 0", m0_if.busy); end
    nvec++; if (m0_if.rd !== 32'h0) begin nfail++; $display("FAIL reset_rd0 got %h want 00000000", m0_if.rd); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int lat, nrdy; logic [31:0] rdv; logic errv;
    xact(2, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (lat !== 3)  begin nfail++; $display("FAIL wr_latency got %0d want 3", lat); end
    nvec++; if (nrdy !== 1) begin nfail++; $display("FAIL wr_ready_count got %0d want 1", nrdy); end
    nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL wr_err got %b want 0", errv); end
    nvec++; if (rdv !== 32'h0) begin nfail++; $display("FAIL wr_rd got %h want 00000000", rdv); end
    xact(2, 1'b0, 32'h10, 32'h0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (lat !== 3)  begin nfail++; $display("FAIL rd_latency got %0d want 3", lat); end
    nvec++; if (nrdy !== 1) begin nfail++; $display("FAIL rd_ready_count got %0d want 1", nrdy); end
    nvec++; if (rdv !== 32'hCAFEF00D) begin nfail++; $display("FAIL rd_data got %h want cafef00d", rdv); end
    nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL rd_err got %b want 0", errv); end
    nvec++; if (m2_if.rd !== 32'hCAFEF00D) begin nfail++; $display("FAIL rd_hold got %h want cafef00d", m2_if.rd); end
  endtask

  task automatic test_busy_timing();
    logic [3:0] exp_busy;
    logic [3:0] exp_rdy;
    exp_busy = 4'b0111;
    exp_rdy  = 4'b0100;
    nvec++; if (m2_if.busy !== 1'b0) begin nfail++; $display("FAIL busy_idle got %b want 0", m2_if.busy); end
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      nvec++;
      if (m2_if.busy !== exp_busy[k-1]) begin
        nfail++; $display("FAIL busy_k%0d got %b want %b", k, m2_if.busy, exp_busy[k-1]);
      end
      nvec++;
      if (m2_if.ready !== exp_rdy[k-1]) begin
        nfail++; $display("FAIL ready_k%0d got %b want %b", k, m2_if.ready, exp_rdy[k-1]);
      end
    end
  endtask

  task automatic test_zero_latency();
    int lat, nrdy; logic [31:0] rdv; logic errv;
    xact(0, 1'b1, 32'h10, 32'h11111111, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (lat !== 1)  begin nfail++; $display("FAIL l0_wr_latency got %0d want 1", lat); end
    nvec++; if (nrdy !== 1) begin nfail++; $display("FAIL l0_wr_count got %0d want 1", nrdy); end
    xact(0, 1'b1, 32'h14, 32'h22222222, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL l0_wr_err got %b want 0", errv); end
    xact(0, 1'b0, 32'h14, 32'h0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (lat !== 1) begin nfail++; $display("FAIL l0_rd_latency got %0d want 1", lat); end
    nvec++; if (rdv !== 32'h22222222) begin nfail++; $display("FAIL l0_rd_data got %h want 22222222", rdv); end
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    nvec++; if (m0_if.ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready1 got %b want 1", m0_if.ready); end
    nvec++; if (m0_if.rd !== 32'h11111111) begin nfail++; $display("FAIL b2b_rd1 got %h want 11111111", m0_if.rd); end
    nvec++; if (m0_if.busy !== 1'b1) begin nfail++; $display("FAIL b2b_busy1 got %b want 1", m0_if.busy); end
    drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
    step();
    nvec++; if (m0_if.ready !== 1'b0) begin nfail++; $display("FAIL b2b_ready2 got %b want 0", m0_if.ready); end
    nvec++; if (m0_if.busy !== 1'b0) begin nfail++; $display("FAIL b2b_busy2 got %b want 0", m0_if.busy); end
    step();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    nvec++; if (m0_if.ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready3 got %b want 1", m0_if.ready); end
    nvec++; if (m0_if.rd !== 32'h22222222) begin nfail++; $display("FAIL b2b_rd3 got %h want 22222222", m0_if.rd); end
    step();
    nvec++; if (m0_if.ready !== 1'b0) begin nfail++; $display("FAIL b2b_ready4 got %b want 0", m0_if.ready); end
    step();
  endtask

  task automatic test_faults();
    int lat, nrdy; logic [31:0] rdv; logic errv;
    xact(2, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL flt_wr0_err got %b want 0", errv); end
    xact(2, 1'b0, 32'h102, 32'h0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (lat !== 3) begin nfail++; $display("FAIL flt_mis_latency got %0d want 3", lat); end
    nvec++; if (errv !== 1'b1) begin nfail++; $display("FAIL flt_mis_err got %b want 1", errv); end
    nvec++; if (rdv !== 32'h0) begin nfail++; $display("FAIL flt_mis_rd got %h want 00000000", rdv); end
    xact(2, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (errv !== 1'b1) begin nfail++; $display("FAIL flt_oor_wr_err got %b want 1", errv); end
    nvec++; if (rdv !== 32'h0) begin nfail++; $display("FAIL flt_oor_wr_rd got %h want 00000000", rdv); end
    xact(2, 1'b1, 32'h1, 32'h0BADBAD0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (errv !== 1'b1) begin nfail++; $display("FAIL flt_mis_wr_err got %b want 1", errv); end
    xact(2, 1'b0, 32'h80000000, 32'h0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (errv !== 1'b1) begin nfail++; $display("FAIL flt_high_err got %b want 1", errv); end
    xact(2, 1'b0, 32'h0, 32'h0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (rdv !== 32'hA5A5A5A5) begin nfail++; $display("FAIL flt_word0 got %h want a5a5a5a5", rdv); end
    nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL flt_word0_err got %b want 0", errv); end
  endtask

  task automatic test_reset_in_wait();
    int lat, nrdy; logic [31:0] rdv; logic errv;
    int cnt;
    xact(2, 1'b1, 32'h20, 32'h55AA55AA, 1'b0, lat, nrdy, rdv, errv);
    drive(2, 1'b1, 1'b1, 32'h20, 32'h1);
    step();
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    nvec++; if (m2_if.busy !== 1'b0) begin nfail++; $display("FAIL rstw_busy got %b want 0", m2_if.busy); end
    nvec++; if (m2_if.ready !== 1'b0) begin nfail++; $display("FAIL rstw_ready got %b want 0", m2_if.ready); end
    step();
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (m2_if.ready) cnt++;
    end
    nvec++; if (cnt !== 0) begin nfail++; $display("FAIL rstw_no_ready got %0d want 0", cnt); end
    xact(2, 1'b0, 32'h20, 32'h0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (rdv !== 32'h55AA55AA) begin nfail++; $display("FAIL rstw_prior got %h want 55aa55aa", rdv); end
  endtask

  task automatic test_latched_inputs();
    int lat, nrdy; logic [31:0] rdv; logic errv;
    xact(2, 1'b1, 32'h30, 32'h12345678, 1'b1, lat, nrdy, rdv, errv);
    nvec++; if (lat !== 3) begin nfail++; $display("FAIL lat_wr_latency got %0d want 3", lat); end
    nvec++; if (rdv !== 32'h0) begin nfail++; $display("FAIL lat_wr_rd got %h want 00000000", rdv); end
    xact(2, 1'b0, 32'h30, 32'h0, 1'b1, lat, nrdy, rdv, errv);
    nvec++; if (rdv !== 32'h12345678) begin nfail++; $display("FAIL lat_rd got %h want 12345678", rdv); end
    nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL lat_rd_err got %b want 0", errv); end
    xact(2, 1'b0, 32'h30, 32'h0, 1'b0, lat, nrdy, rdv, errv);
    nvec++; if (rdv !== 32'h12345678) begin nfail++; $display("FAIL lat_rd2 got %h want 12345678", rdv); end
  endtask

  task automatic test_sweep();
    int lat, nrdy; logic [31:0] rdv; logic errv;
    logic [31:0] exp;
    for (int i = 0; i < 64; i++) begin
      exp = 32'(i) * 32'h01010101;
      xact(2, 1'b1, 32'(i) << 2, exp, 1'b0, lat, nrdy, rdv, errv);
      nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL sweep_wr_err%0d got %b want 0", i, errv); end
    end
    for (int i = 0; i < 64; i++) begin
      exp = 32'(i) * 32'h01010101;
      xact(2, 1'b0, 32'(i) << 2, 32'h0, 1'b0, lat, nrdy, rdv, errv);
      nvec++; if (rdv !== exp) begin nfail++; $display("FAIL sweep_rd%0d got %h want %h", i, rdv, exp); end
      nvec++; if (errv !== 1'b0) begin nfail++; $display("FAIL sweep_rd_err%0d got %b want 0", i, errv); end
    end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    test_reset();
    test_write_read();
    test_busy_timing();
    test_zero_latency();
    test_back_to_back();
    test_faults();
    test_reset_in_wait();
    test_latched_inputs();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit words in the unified instruction/data store; it SHALL be a power of two, 4..1024.
REQ-002 Parameter LATENCY, default 2, SHALL set the wait cycles between request acceptance and response; range 0..15.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Port req, input, 1, SHALL mark a valid access request from the multi-cycle datapath/controller.
REQ-006 Port we, input, 1, SHALL select write (1) or read (0); sampled with req.
REQ-007 Port a, input, 32, SHALL carry the byte address (Adr); sampled with req.
REQ-008 Port wd, input, 32, SHALL carry the write data (WriteData); sampled with req.
REQ-009 Port rd, output, 32, SHALL return the read data (ReadData).
REQ-010 Port ready, output, 1, SHALL pulse high for exactly one cycle per completed access.
REQ-011 Port busy, output, 1, SHALL be high while a transaction is outstanding (WAIT or RESP).
REQ-012 Port err, output, 1, SHALL flag a faulting access; valid only when ready=1.

Function
REQ-013 FSM SHALL have states IDLE, WAIT, RESP; only IDLE accepts requests.
REQ-014 IDLE with req=1 SHALL latch a, we and wd, load the wait counter with LATENCY, and go to WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-015 IDLE with req=0 SHALL remain in IDLE; req, a, we, wd changes in WAIT/RESP SHALL be ignored.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where it reaches 0; total WAIT occupancy is exactly LATENCY cycles.
REQ-017 Request accepted in cycle T SHALL produce ready=1 in cycle T+1+LATENCY, and in no other cycle.
REQ-018 RESP SHALL last one cycle, assert ready, and return to IDLE; a req held high in RESP SHALL be accepted in the following IDLE cycle (back-to-back: one idle cycle between responses).
REQ-019 Word index SHALL be latched a[31:2]; access is faulting if a[1:0]!=0 or a[31:2]>=DEPTH_WORDS.
REQ-020 Non-faulting write SHALL commit latched wd to the indexed word on the edge entering RESP; faulting writes SHALL not modify the store.
REQ-021 Non-faulting read SHALL drive the indexed word on rd during RESP; faulting read SHALL drive rd=32'h0000_0000.
REQ-022 Write response SHALL drive rd=32'h0000_0000; err=1 in RESP iff access faulted, else 0.
REQ-023 rd and err SHALL hold their RESP values until the next RESP cycle.
REQ-024 A read to a word written by the immediately preceding transaction SHALL return the new data.
REQ-025 busy SHALL be 1 in WAIT and RESP, 0 in IDLE.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, counter=0, ready=0, busy=0, err=0, rd=32'h0000_0000.
REQ-027 Reset during WAIT SHALL abort the transaction with no write and no ready pulse.
REQ-028 Store contents SHALL not be cleared by reset; power-up contents are undefined.

Verification
REQ-029 LATENCY=2: write a=0x10, wd=0xCAFEF00D accepted at T -> ready only at T+3, err=0, rd=0; then read a=0x10 -> rd=0xCAFEF00D, err=0.
REQ-030 LATENCY=0: read accepted at T -> ready at T+1; req held with new address -> second ready at T+3.
REQ-031 Read a=0x102 -> ready with err=1, rd=0; write a=0x100 (DEPTH_WORDS=64) -> err=1, word 0 unchanged on read-back.
REQ-032 Reset asserted one cycle into WAIT of write a=0x20, wd=0x1 -> no ready, busy=0 immediately; subsequent read a=0x20 returns prior contents.
REQ-033 Changing a/we/wd during WAIT -> response reflects values latched at acceptance.
REQ-034 Write then read every word 0..DEPTH_WORDS-1 with data=index*0x01010101 -> all read-backs match, err=0 throughout.
